// File: rtl/acc_seq_ctrl.sv
// Purpose: sequenced accumulator; sums i_count unsigned 32-bit operand beats and presents sum + sticky carry.
// Latency: result valid one cycle after the last accepted beat (one cycle after start when i_count == 0).
// Backpressure: o_in_ready high only in ACCUM; result held in DONE until i_out_ready, no new start until then.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start, i_count          start request and operand count (sampled in IDLE only)
//   o_busy                    high while a job is in ACCUM or DONE
//   i_in_valid/o_in_ready     operand beat handshake, i_in_data is the operand
//   o_out_valid/i_out_ready   result handshake, o_out_sum / o_out_carry carry the result

// Team 32-bit adder: {o_c32, o_v} = i_va + i_vb + i_c0.
module Accumulator32bit (
   input  logic [31:0] i_va,
   input  logic [31:0] i_vb,
   input  logic        i_c0,
   output logic [31:0] o_v,
   output logic        o_c32
);
   logic [32:0] sum_w;

   assign sum_w = {1'b0, i_va} + {1'b0, i_vb} + {32'd0, i_c0};
   assign o_v   = sum_w[31:0];
   assign o_c32 = sum_w[32];
endmodule

module acc_seq_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_count,
   output logic             o_busy,
   input  logic             i_in_valid,
   input  logic [31:0]      i_in_data,
   output logic             o_in_ready,
   output logic             o_out_valid,
   output logic [31:0]      o_out_sum,
   output logic             o_out_carry,
   input  logic             i_out_ready
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   state_t           state;
   logic [31:0]      acc;
   logic             carry_flag;
   logic [CNT_W-1:0] cnt;

   logic [31:0]      add_v;
   logic             add_c;
   logic             beat_acc;

   // Single adder instance; carry-in is tied low, the carry-out feeds the sticky flag.
   Accumulator32bit u_add (
      .i_va  (acc),
      .i_vb  (i_in_data),
      .i_c0  (1'b0),
      .o_v   (add_v),
      .o_c32 (add_c)
   );

   // o_in_ready is registered and is high exactly while in ACCUM.
   assign beat_acc = o_in_ready & i_in_valid;

   // The accumulator itself is the result register: it only moves on accepted
   // beats, so it is stable through DONE and keeps its value back in IDLE.
   assign o_out_sum   = acc;
   assign o_out_carry = carry_flag;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         acc         <= 32'd0;
         carry_flag  <= 1'b0;
         cnt         <= CNT_ZERO;
         o_busy      <= 1'b0;
         o_in_ready  <= 1'b0;
         o_out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  acc        <= 32'd0;
                  carry_flag <= 1'b0;
                  cnt        <= i_count;
                  o_busy     <= 1'b1;
                  if (i_count != CNT_ZERO) begin
                     state      <= S_ACCUM;
                     o_in_ready <= 1'b1;
                  end else begin
                     // Zero-length job goes straight to an all-zero result.
                     state       <= S_DONE;
                     o_out_valid <= 1'b1;
                  end
               end
            end

            S_ACCUM: begin
               if (beat_acc) begin
                  acc        <= add_v;
                  carry_flag <= carry_flag | add_c;
                  cnt        <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     state       <= S_DONE;
                     o_in_ready  <= 1'b0;
                     o_out_valid <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               // i_start is deliberately ignored here, even on the handshake cycle.
               if (i_out_ready) begin
                  state       <= S_IDLE;
                  o_out_valid <= 1'b0;
                  o_busy      <= 1'b0;
               end
            end

            default: begin
               state       <= S_IDLE;
               o_busy      <= 1'b0;
               o_in_ready  <= 1'b0;
               o_out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Purpose: directed self-checking bench for acc_seq_ctrl.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises stalled operand beats and a held result with i_out_ready low.
module tb_acc_seq_ctrl;
   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic [7:0]  i_count;
   logic        o_busy;
   logic        i_in_valid;
   logic [31:0] i_in_data;
   logic        o_in_ready;
   logic        o_out_valid;
   logic [31:0] o_out_sum;
   logic        o_out_carry;
   logic        i_out_ready;

   int checks = 0;
   int errors = 0;

   acc_seq_ctrl #(.CNT_W(8)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_count     (i_count),
      .o_busy      (o_busy),
      .i_in_valid  (i_in_valid),
      .i_in_data   (i_in_data),
      .o_in_ready  (o_in_ready),
      .o_out_valid (o_out_valid),
      .o_out_sum   (o_out_sum),
      .o_out_carry (o_out_carry),
      .i_out_ready (i_out_ready)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // busy / in_ready / out_valid as one 3-bit vector
   function automatic logic [31:0] ctl();
      return {29'd0, o_busy, o_in_ready, o_out_valid};
   endfunction

   initial begin
      i_rst_n     = 1'b0;
      i_start     = 1'b0;
      i_count     = 8'd0;
      i_in_valid  = 1'b0;
      i_in_data   = 32'd0;
      i_out_ready = 1'b0;

      // Reset state
      #23;
      chk("rst_ctl",   ctl(),       32'h0);
      chk("rst_sum",   o_out_sum,   32'h0);
      chk("rst_carry", {31'd0, o_out_carry}, 32'h0);
      #4 i_rst_n = 1'b1;
      step();

      // count=2, beats 1,1 -> sum 2, carry 0
      i_start = 1'b1; i_count = 8'd2;
      step();
      i_start = 1'b0;
      chk("t1_accum_ctl", ctl(), 32'h6);
      i_in_valid = 1'b1; i_in_data = 32'h1;
      step();
      chk("t1_beat1_ctl", ctl(), 32'h6);
      chk("t1_beat1_sum", o_out_sum, 32'h1);
      step();
      i_in_valid = 1'b0;
      chk("t1_done_ctl",   ctl(), 32'h5);
      chk("t1_done_sum",   o_out_sum, 32'h2);
      chk("t1_done_carry", {31'd0, o_out_carry}, 32'h0);
      i_out_ready = 1'b1;
      step();
      i_out_ready = 1'b0;
      chk("t1_idle_ctl", ctl(), 32'h0);
      chk("t1_idle_sum", o_out_sum, 32'h2);

      // count=3, beats FFFFFFFF,2,1 -> sum 2, carry 1
      i_start = 1'b1; i_count = 8'd3;
      step();
      i_start = 1'b0;
      chk("t2_clr_sum", o_out_sum, 32'h0);
      i_in_valid = 1'b1; i_in_data = 32'hFFFF_FFFF;
      step();
      i_in_data = 32'h2;
      step();
      chk("t2_wrap_sum",   o_out_sum, 32'h1);
      chk("t2_wrap_carry", {31'd0, o_out_carry}, 32'h1);
      i_in_data = 32'h1;
      step();
      i_in_valid = 1'b0;
      chk("t2_done_ctl",   ctl(), 32'h5);
      chk("t2_done_sum",   o_out_sum, 32'h2);
      chk("t2_done_carry", {31'd0, o_out_carry}, 32'h1);
      i_out_ready = 1'b1;
      step();
      i_out_ready = 1'b0;
      chk("t2_idle_carry", {31'd0, o_out_carry}, 32'h1);

      // count=0 -> result the cycle after start, beats offered are not taken
      i_start = 1'b1; i_count = 8'd0;
      i_in_valid = 1'b1; i_in_data = 32'h55;
      step();
      i_start = 1'b0;
      chk("t3_done_ctl",   ctl(), 32'h5);
      chk("t3_done_sum",   o_out_sum, 32'h0);
      chk("t3_done_carry", {31'd0, o_out_carry}, 32'h0);
      step();
      chk("t3_hold_sum", o_out_sum, 32'h0);
      i_in_valid = 1'b0;
      i_out_ready = 1'b1;
      step();
      i_out_ready = 1'b0;
      chk("t3_idle_ctl", ctl(), 32'h0);

      // count=2, beat 5, 3 idle cycles with start pulses, beat 6, 5-cycle result stall
      i_start = 1'b1; i_count = 8'd2;
      step();
      i_start = 1'b0;
      i_in_valid = 1'b1; i_in_data = 32'h5;
      step();
      i_in_valid = 1'b0; i_in_data = 32'hDEAD;
      for (int k = 0; k < 3; k++) begin
         i_start = (k == 1); i_count = 8'd7;
         step();
         chk("t4_gap_ctl", ctl(), 32'h6);
         chk("t4_gap_sum", o_out_sum, 32'h5);
      end
      i_start = 1'b0;
      i_in_valid = 1'b1; i_in_data = 32'h6;
      step();
      i_in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("t4_stall_ctl", ctl(), 32'h5);
         chk("t4_stall_sum", o_out_sum, 32'hB);
         i_start = (k == 2); i_count = 8'd1;
         step();
      end
      chk("t4_stall_end_ctl", ctl(), 32'h5);
      // start and out_ready together: handshake only
      i_start = 1'b1; i_out_ready = 1'b1;
      step();
      i_start = 1'b0; i_out_ready = 1'b0;
      chk("t4_nostart_ctl", ctl(), 32'h0);
      step();
      chk("t4_idle2_ctl", ctl(), 32'h0);
      chk("t4_idle2_sum", o_out_sum, 32'hB);

      // count=4, one beat 9, then asynchronous reset mid-ACCUM
      i_start = 1'b1; i_count = 8'd4;
      step();
      i_start = 1'b0;
      i_in_valid = 1'b1; i_in_data = 32'h9;
      step();
      i_in_valid = 1'b0;
      chk("t5_part_sum", o_out_sum, 32'h9);
      #2 i_rst_n = 1'b0;
      #1;
      chk("t5_rst_ctl",   ctl(), 32'h0);
      chk("t5_rst_sum",   o_out_sum, 32'h0);
      chk("t5_rst_carry", {31'd0, o_out_carry}, 32'h0);
      i_start = 1'b1; i_count = 8'd1;
      #1 i_rst_n = 1'b1;
      step();
      i_start = 1'b0;
      chk("t5_restart_ctl", ctl(), 32'h6);
      i_in_valid = 1'b1; i_in_data = 32'h7;
      step();
      i_in_valid = 1'b0;
      chk("t5_done_ctl",   ctl(), 32'h5);
      chk("t5_done_sum",   o_out_sum, 32'h7);
      chk("t5_done_carry", {31'd0, o_out_carry}, 32'h0);
      i_out_ready = 1'b1;
      step();
      i_out_ready = 1'b0;
      chk("t5_idle_ctl", ctl(), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/acc_seq_ctrl.md
ACC_SEQ_CTRL -- requirements
Module: acc_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the operand-count input and the internal beat counter.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_start  input  1  start request; sampled only in IDLE.
REQ-005 SHALL have port i_count  input  CNT_W  number of operands to accumulate; latched on an accepted start.
REQ-006 SHALL have port o_busy  output  1  high in ACCUM and DONE.
REQ-007 SHALL have port i_in_valid  input  1  operand beat valid.
REQ-008 SHALL have port i_in_data  input  32  unsigned operand.
REQ-009 SHALL have port o_in_ready  output  1  operand beat ready.
REQ-010 SHALL have port o_out_valid  output  1  result valid.
REQ-011 SHALL have port o_out_sum  output  32  accumulated sum, modulo 2^32.
REQ-012 SHALL have port o_out_carry  output  1  sticky unsigned overflow flag.
REQ-013 SHALL have port i_out_ready  input  1  result consumer ready.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-015 SHALL perform each addition through one instance of the team 32-bit adder Accumulator32bit, with i_va = accumulator, i_vb = i_in_data, i_c0 = 0.
REQ-016 In IDLE, SHALL drive o_in_ready = 0, o_out_valid = 0, o_busy = 0.
REQ-017 On i_start = 1 in IDLE with i_count != 0, SHALL clear the accumulator and carry flag, load the beat counter with i_count, and enter ACCUM next cycle.
REQ-018 On i_start = 1 in IDLE with i_count == 0, SHALL clear the accumulator and carry flag and enter DONE next cycle (result 0x00000000, carry 0).
REQ-019 SHALL ignore i_start in ACCUM and DONE; the latched count is unaffected.
REQ-020 In ACCUM, SHALL drive o_in_ready = 1; a beat is accepted when i_in_valid and o_in_ready are both 1 on a rising edge.
REQ-021 On each accepted beat, SHALL update accumulator <= adder o_v, carry flag <= carry flag OR adder o_c32, beat counter <= counter - 1.
REQ-022 Cycles in ACCUM with i_in_valid = 0 SHALL leave all state unchanged.
REQ-023 When the beat accepted has counter == 1, SHALL enter DONE next cycle; o_out_valid is high the cycle after the last accepted beat.
REQ-024 In DONE, SHALL drive o_out_valid = 1, o_in_ready = 0, and hold o_out_sum and o_out_carry stable until the handshake completes.
REQ-025 On i_out_ready = 1 in DONE, SHALL enter IDLE next cycle; o_out_sum and o_out_carry retain their last value in IDLE.
REQ-026 SHALL wrap the sum modulo 2^32; the carry flag, once set, stays set until the next accepted start or reset.
REQ-027 i_start and i_out_ready both high in DONE SHALL complete the result handshake only; start is not accepted that cycle.

Reset
REQ-028 On i_rst_n = 0, SHALL immediately force state IDLE, accumulator 0, carry flag 0, counter 0, o_out_valid 0, o_in_ready 0, o_busy 0, o_out_sum 0x00000000, o_out_carry 0.
REQ-029 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial or pending result; no output handshake occurs for it.
REQ-030 After i_rst_n deasserts, the first rising edge SHALL be able to accept a start.

Verification
REQ-031 Start count=2, beats 0x00000001, 0x00000001 -> o_out_valid one cycle after second beat, sum 0x00000002, carry 0.
REQ-032 Start count=3, beats 0xFFFFFFFF, 0x00000002, 0x00000001 -> sum 0x00000002, carry 1.
REQ-033 Start count=0 -> o_out_valid the cycle after start, sum 0x00000000, carry 0, no beats accepted.
REQ-034 Start count=2, beats 0x00000005 and 0x00000006 with 3 idle cycles between them, i_out_ready low for 5 cycles -> sum 0x0000000B held stable, o_in_ready 0 throughout DONE, i_start pulses during busy ignored.
REQ-035 Start count=4, one beat 0x00000009 accepted, then i_rst_n low -> all outputs 0 asynchronously; after release, start count=1, beat 0x00000007 -> sum 0x00000007, carry 0.
